// File: rtl/mips_mdu_pkg.sv
// mdu_pkg: shared encodings, constants and helpers for the MIPS multiply/divide unit
package mdu_pkg;
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;
  localparam int DIV_ITERS = 32;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;
  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? -x : x;
  endfunction
endpackage

// File: rtl/mips_mdu_if.sv
// mips_mdu_if: Execute/Decode-side bundle of the multiply/divide unit
//   master (core side) drives StartE/OpE/SrcAE/SrcBE/MtHiE/MtLoE/FlushE/MdUseD
//   slave (mips_mdu) drives Hi/Lo/Busy/StallMD
interface mips_mdu_if;
  logic        StartE;
  logic [1:0]  OpE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        MtHiE;
  logic        MtLoE;
  logic        FlushE;
  logic        MdUseD;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        StallMD;
  modport master (output StartE, OpE, SrcAE, SrcBE, MtHiE, MtLoE, FlushE, MdUseD,
                  input Hi, Lo, Busy, StallMD);
  modport slave (input StartE, OpE, SrcAE, SrcBE, MtHiE, MtLoE, FlushE, MdUseD,
                 output Hi, Lo, Busy, StallMD);
endinterface

// File: rtl/mips_mdu_div_core.sv
// mdu_div_core: iterative restoring divider on magnitudes, one quotient bit per step
//   load_i captures dividend_i/divisor_i; step_i runs one iteration
//   quot_o/rem_o are the magnitude results; done_o flags the final iteration
module mdu_div_core
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o,
  output logic        done_o
);
  logic [31:0] q_q, r_q, d_q;
  logic [5:0]  cnt_q;
  logic [32:0] sh;
  logic        ge;
  // the dividend shifts out of q_q into the partial remainder while quotient bits shift in
  assign sh = {r_q, q_q[31]};
  assign ge = sh >= {1'b0, d_q};
  assign quot_o = q_q;
  assign rem_o  = r_q;
  assign done_o = cnt_q == 6'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q_q   <= '0;
      r_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      q_q   <= dividend_i;
      r_q   <= '0;
      d_q   <= divisor_i;
      cnt_q <= 6'(DIV_ITERS);
    end else if (step_i && cnt_q != 6'd0) begin
      q_q   <= {q_q[30:0], ge};
      r_q   <= ge ? 32'(sh - {1'b0, d_q}) : sh[31:0];
      cnt_q <= cnt_q - 6'd1;
    end
endmodule

// File: rtl/mips_mdu.sv
// mips_mdu: iterative MULT/MULTU/DIV/DIVU unit with HI/LO and MTHI/MTLO, stall requester
//   clk, rst_n (async active-low); mdu: mips_mdu_if.slave carrying Execute inputs,
//   MdUseD from Decode, and Hi/Lo/Busy/StallMD outputs
module mips_mdu
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input logic       clk,
  input logic       rst_n,
  mips_mdu_if.slave mdu
);
  state_e      state_q;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q, hi_q, lo_q;
  logic        busy_q;
  logic [2:0]  cnt_q;
  logic        accept, mv, sa, sb, q_neg, r_neg, div_done;
  logic [63:0] ea, eb, prod;
  logic [31:0] quot, rem, fix_hi, fix_lo;
  assign accept = state_q == IDLE && mdu.StartE && !mdu.FlushE;
  // a move presented with an accepted start is dropped
  assign mv = state_q == IDLE && !mdu.FlushE && !mdu.StartE;
  assign sa = !op_q[0] && a_q[31];
  assign sb = !op_q[0] && b_q[31];
  assign ea = {{32{sa}}, a_q};
  assign eb = {{32{sb}}, b_q};
  assign prod = ea * eb;
  assign q_neg = !op_q[0] && (a_q[31] ^ b_q[31]);
  assign r_neg = !op_q[0] && a_q[31];
  // divide by zero bypasses sign fix-up: all-ones quotient, raw dividend as remainder
  assign fix_lo = b_q == 32'd0 ? '1 : q_neg ? -quot : quot;
  assign fix_hi = b_q == 32'd0 ? a_q : r_neg ? -rem : rem;
  assign mdu.Hi = hi_q;
  assign mdu.Lo = lo_q;
  assign mdu.Busy = busy_q;
  assign mdu.StallMD = busy_q && mdu.MdUseD;
  mdu_div_core u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept && mdu.OpE[1]),
    .step_i     (state_q == DIV),
    .dividend_i (mag(mdu.SrcAE, !mdu.OpE[0])),
    .divisor_i  (mag(mdu.SrcBE, !mdu.OpE[0])),
    .quot_o     (quot),
    .rem_o      (rem),
    .done_o     (div_done)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE:
          if (accept) begin
            op_q    <= mdu.OpE;
            a_q     <= mdu.SrcAE;
            b_q     <= mdu.SrcBE;
            busy_q  <= 1'b1;
            cnt_q   <= 3'(MUL_LAT - 1);
            state_q <= mdu.OpE[1] ? DIV : MUL;
          end else if (mv) begin
            if (mdu.MtHiE) hi_q <= mdu.SrcAE;
            if (mdu.MtLoE) lo_q <= mdu.SrcAE;
          end
        MUL:
          if (cnt_q == 3'd0) begin
            hi_q    <= prod[63:32];
            lo_q    <= prod[31:0];
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else cnt_q <= cnt_q - 3'd1;
        DIV:
          if (div_done) state_q <= FIX;
        FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_mips_mdu.sv
// tb_mips_mdu: directed scoreboard bench for mips_mdu
module tb_mips_mdu;
  import mdu_pkg::*;
  localparam int MUL_LAT = 4;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  exp_t sbq[$];
  mips_mdu_if bus ();
  mips_mdu #(.MUL_LAT(MUL_LAT)) dut (.clk(clk), .rst_n(rst_n), .mdu(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input bit use_d, input bit mv, input bit poke);
    int n;
    int st;
    logic [31:0] h0;
    logic [31:0] l0;
    exp_t e;
    sbq.push_back('{eh, el, op[1] ? 33 : MUL_LAT});
    h0 = bus.Hi;
    l0 = bus.Lo;
    bus.StartE = 1'b1;
    bus.OpE = op;
    bus.SrcAE = a;
    bus.SrcBE = b;
    bus.MtHiE = mv;
    bus.MtLoE = mv;
    bus.MdUseD = use_d;
    n = 0;
    st = 0;
    do begin
      @(negedge clk);
      n++;
      bus.StartE = poke && n == 2;
      bus.MtHiE = 1'b0;
      bus.MtLoE = 1'b0;
      if (poke && n == 2) begin
        bus.OpE = op ^ 2'b10;
        bus.SrcAE = ~a;
        bus.SrcBE = 32'h5;
      end
      if (bus.StallMD) st++;
      if (mv && n == 1) begin
        chk({tag, "_mvhi_dropped"}, {32'h0, bus.Hi}, {32'h0, h0});
        chk({tag, "_mvlo_dropped"}, {32'h0, bus.Lo}, {32'h0, l0});
      end
    end while (bus.Busy && n < 100);
    bus.StartE = 1'b0;
    bus.MdUseD = 1'b0;
    e = sbq.pop_front();
    chk({tag, "_latency"}, 64'(n - 1), 64'(e.lat));
    chk({tag, "_hi"}, {32'h0, bus.Hi}, {32'h0, e.hi});
    chk({tag, "_lo"}, {32'h0, bus.Lo}, {32'h0, e.lo});
    chk({tag, "_stall_cycles"}, 64'(st), 64'(use_d ? e.lat : 0));
  endtask
  initial begin
    bus.StartE = 1'b0;
    bus.OpE = MD_MULT;
    bus.SrcAE = '0;
    bus.SrcBE = '0;
    bus.MtHiE = 1'b0;
    bus.MtLoE = 1'b0;
    bus.FlushE = 1'b0;
    bus.MdUseD = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_hi", {32'h0, bus.Hi}, 64'h0);
    chk("reset_lo", {32'h0, bus.Lo}, 64'h0);
    chk("reset_busy", {63'h0, bus.Busy}, 64'h0);
    chk("reset_stall", {63'h0, bus.StallMD}, 64'h0);
    rst_n = 1'b1;
    bus.MdUseD = 1'b0;
    @(negedge clk);
    run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1, 1'b0, 1'b0);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFE, 32'h3, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0, 1'b0, 1'b0);
    run_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0);
    run_op("div_7_m2", MD_DIV, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    run_op("divu_by0", MD_DIVU, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("div_by0", MD_DIV, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("divu_poke", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, 1'b1);
    run_op("mult_poke", MD_MULT, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 1'b1, 1'b0, 1'b1);
    bus.MtHiE = 1'b1;
    bus.MtLoE = 1'b1;
    bus.SrcAE = 32'hAA;
    @(negedge clk);
    bus.MtHiE = 1'b0;
    bus.MtLoE = 1'b0;
    chk("mt_hi", {32'h0, bus.Hi}, 64'hAA);
    chk("mt_lo", {32'h0, bus.Lo}, 64'hAA);
    bus.FlushE = 1'b1;
    bus.StartE = 1'b1;
    bus.MtHiE = 1'b1;
    bus.OpE = MD_MULT;
    bus.SrcAE = 32'h55;
    bus.SrcBE = 32'h2;
    @(negedge clk);
    bus.FlushE = 1'b0;
    bus.StartE = 1'b0;
    bus.MtHiE = 1'b0;
    chk("flush_busy", {63'h0, bus.Busy}, 64'h0);
    chk("flush_hi", {32'h0, bus.Hi}, 64'hAA);
    chk("flush_lo", {32'h0, bus.Lo}, 64'hAA);
    run_op("multu_mv", MD_MULTU, 32'h2, 32'h3, 32'h0, 32'h6, 1'b0, 1'b1, 1'b0);
    bus.StartE = 1'b1;
    bus.OpE = MD_DIVU;
    bus.SrcAE = 32'h1000;
    bus.SrcBE = 32'h3;
    @(negedge clk);
    bus.StartE = 1'b0;
    repeat (9) @(negedge clk);
    chk("middiv_busy", {63'h0, bus.Busy}, 64'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {63'h0, bus.Busy}, 64'h0);
    chk("rst_hi", {32'h0, bus.Hi}, 64'h0);
    chk("rst_lo", {32'h0, bus.Lo}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("divu_after_rst", MD_DIVU, 32'h1000, 32'h3, 32'h1, 32'h555, 1'b1, 1'b0, 1'b0);
    chk("sb_empty", 64'(sbq.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
